muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the architectural HI/LO registers.
- Sits beside the execute stage. Decode supplies the op and the rs/rt values; the block runs an iterative shift-add multiply or restoring divide, one bit per cycle.
- Raises a stall to the hazard logic while HI/LO are not yet valid and an instruction needs them or needs the unit.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  begin operation in op; sampled only in IDLE.
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- operand_a  input  WIDTH  rs value (multiplicand/dividend).
- operand_b  input  WIDTH  rt value (multiplier/divisor).
- hilo_read  input  1  decode holds MFHI/MFLO.
- mthi  input  1  write operand_a to HI.
- mtlo  input  1  write operand_a to LO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight.
- stall  output  1  to hazard unit; freeze fetch/decode.
- done  output  1  one-cycle pulse: HI/LO just updated by an operation.
- div_by_zero  output  1  one-cycle pulse with done for DIV/DIVU with operand_b=0.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, iteration counter=0. Any operation in flight is aborted; its result is never written.
- States: IDLE, CALC, FINISH.
- IDLE, start=1, edge E0:
  - Latch op.
  - Latch |operand_a| and |operand_b|. Absolute value applies only for MULT/DIV; MULTU/DIVU use raw values.
  - Latch the result sign:
    - MULT: sign_a XOR sign_b.
    - DIV quotient: sign_a XOR sign_b.
    - DIV remainder: sign_a.
  - Counter=0. Go to CALC.
  - Exception: divide with operand_b=0 goes directly to FINISH with a zero-divide flag.
- CALC: one iteration per edge; counter increments. After ITER iterations (edge E32), go to FINISH.
  - Multiply: 64-bit shift-add into {acc_hi, acc_lo}.
  - Divide: restoring shift-subtract; quotient in acc_lo, remainder in acc_hi.
- FINISH (edge E33): write hi/lo, go to IDLE. done=1 for the cycle after E33; div_by_zero=1 in the same cycle when applicable.
  - Multiply: {hi,lo} = signed-corrected 64-bit product (two's-complement negate when the sign flag is set).
  - Divide: lo = quotient, hi = remainder, each negated per its own sign flag.
  - Divide by zero: lo=all ones, hi=operand_a as latched raw. Latency 2 edges (E0 to FINISH at E1).
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural result of the datapath; no special handling.
- busy=1 from the cycle after E0 through the cycle ending at the FINISH edge; 0 otherwise.
- stall = busy AND (start OR hilo_read OR mthi OR mtlo). Combinational. No stall in IDLE.
- Requests while busy: start, mthi and mtlo are ignored. Decode re-presents them after stall drops. hi/lo keep their old values until FINISH.
- mthi/mtlo in IDLE: hi (or lo) <= operand_a at the next edge. Both may be set together.
- start together with mthi/mtlo in IDLE: start wins; the move is dropped (not a legal single instruction).
- hi/lo are registered outputs. MFHI in the cycle after done sees the new values.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at E0 -> done in the cycle after E33; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Same with op=MULTU -> hi=0x00000006, lo=0xFFFFFFEB.
- DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 7 -> lo=14, hi=2.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5 / 0 -> FINISH at E1; done=1 and div_by_zero=1 in the following cycle; lo=0xFFFFFFFF, hi=5.
- Hazard/abort:
  - During MULT, hilo_read=1 at cycle 10 -> stall=1 until busy falls; hi/lo unchanged before done.
  - mthi issued while busy -> no effect.
  - reset_n low at cycle 20 -> hi=lo=0, busy=0 immediately; no done pulse afterwards.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// One product or quotient bit per cycle; stalls decode while HI/LO or the unit are unavailable.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hilo_read,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero
);

  // state    | meaning
  // S_IDLE   | accept start or mthi/mtlo; HI/LO valid
  // S_CALC   | one shift-add / shift-subtract step per cycle
  // S_FINISH | sign-correct the accumulator and write HI/LO
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  localparam int CW = $clog2(ITER + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opm_q, opm_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;

  // op[0]=0 selects the signed variants (MULT, DIV)
  assign sign_a = ~op[0] & operand_a[WIDTH-1];
  assign sign_b = ~op[0] & operand_b[WIDTH-1];
  assign abs_a  = sign_a ? -operand_a : operand_a;
  assign abs_b  = sign_b ? -operand_b : operand_b;

  assign add_sum   = {1'b0, acc_hi_q} + {1'b0, opm_q};
  assign rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opm_q};
  assign prod_raw  = {acc_hi_q, acc_lo_q};
  assign prod_fix  = neg_lo_q ? -prod_raw : prod_raw;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opm_d    = opm_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          cnt_d    = '0;
          dz_d     = 1'b0;
          acc_hi_d = '0;
          neg_lo_d = sign_a ^ sign_b;
          state_d  = S_CALC;
          if (op[1]) begin
            acc_lo_d = abs_a;
            opm_d    = abs_b;
            neg_hi_d = sign_a;
          end else begin
            acc_lo_d = abs_b;
            opm_d    = abs_a;
            neg_hi_d = 1'b0;
          end
          // Zero divisor: preload the fixed result and skip the iterations
          if (op[1] && (operand_b == '0)) begin
            dz_d     = 1'b1;
            acc_hi_d = operand_a;
            acc_lo_d = '1;
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d  = S_FINISH;
          end
        end else begin
          if (mthi) hi_d = operand_a;
          if (mtlo) lo_d = operand_a;
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          if (!rem_diff[WIDTH]) begin
            acc_hi_d = rem_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_d = rem_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (acc_lo_q[0]) begin
            acc_hi_d = add_sum[WIDTH:1];
            acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
          end else begin
            acc_hi_d = {1'b0, acc_hi_q[WIDTH-1:1]};
            acc_lo_d = {acc_hi_q[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        if (cnt_q == CW'(ITER - 1)) state_d = S_FINISH;
      end

      S_FINISH: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        dbz_d   = dz_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opm_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opm_q    <= opm_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign stall       = busy & (start | hilo_read | mthi | mtlo);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vectors, hazard/abort sequences
// and random operations compared with an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        hilo_read, mthi, mtlo;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_by_zero;

  int passed = 0;
  int total  = 0;

  muldiv_sequencer #(.WIDTH(32), .ITER(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .hilo_read(hilo_read), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall),
    .done(done), .div_by_zero(div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: returns {div_by_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, qq, rr;
    logic [63:0] p;
    logic z;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    z  = 1'b0;
    p  = '0;
    case (o)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          z = 1'b1;
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          qq = sa / sb;
          rr = sa % sb;
          p  = {rr[31:0], qq[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    return {z, p};
  endfunction

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int k, bcnt, lat_exp;
    logic seen, dz_seen;
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clock);
    start = 1'b0;
    k = 1; bcnt = 0; seen = 1'b0; dz_seen = 1'b0;
    while (k <= 100 && !seen) begin
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        dz_seen = div_by_zero;
      end else begin
        @(negedge clock);
        k++;
      end
    end
    lat_exp = (o[1] && b == 32'd0) ? 2 : 34;
    check({nm, " latency"}, 64'(k), 64'(lat_exp));
    check({nm, " busy_cycles"}, 64'(bcnt), 64'(lat_exp - 1));
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
    check({nm, " div_by_zero"}, 64'(dz_seen), 64'(edz));
    @(negedge clock);
    check({nm, " done_one_cycle"}, 64'({done, div_by_zero}), 64'(0));
  endtask

  vec_t vecs[10];

  initial begin
    logic [64:0] m;
    logic [31:0] h0, l0, ra, rb;
    logic [1:0]  ro;
    int k, stall_bad, hold_bad, dones;

    vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'd1, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB, 1'b0};
    vecs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[9] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    reset_n = 1'b0; start = 1'b0; op = 2'd0; operand_a = '0; operand_b = '0;
    hilo_read = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clock);
    check("reset hi", 64'(hi), 64'(0));
    check("reset lo", 64'(lo), 64'(0));
    check("reset busy_done_dz", 64'({busy, done, div_by_zero}), 64'(0));
    reset_n = 1'b1;

    // Moves in IDLE, and no stall when idle
    @(negedge clock);
    mthi = 1'b1; operand_a = 32'h1111_2222; hilo_read = 1'b1;
    #1 check("idle stall", 64'(stall), 64'(0));
    @(negedge clock);
    check("mthi hi", 64'(hi), 64'h1111_2222);
    check("mthi lo untouched", 64'(lo), 64'(0));
    mthi = 1'b0; mtlo = 1'b1; operand_a = 32'h3333_4444; hilo_read = 1'b0;
    @(negedge clock);
    check("mtlo lo", 64'(lo), 64'h3333_4444);
    mthi = 1'b1; mtlo = 1'b1; operand_a = 32'hA5A5_5A5A;
    @(negedge clock);
    check("mthi+mtlo", 64'({hi, lo}), {32'hA5A5_5A5A, 32'hA5A5_5A5A});
    mthi = 1'b0; mtlo = 1'b0;

    for (int i = 0; i < 10; i++) begin
      m = model(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("model_vs_table%0d", i), 64'(m), {vecs[i].hi, vecs[i].lo});
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
    end

    // start together with mthi: start wins, move dropped
    @(negedge clock);
    mthi = 1'b1; mtlo = 1'b1; operand_a = 32'd11; operand_b = 32'd4;
    @(negedge clock);
    h0 = hi; l0 = lo;
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge clock);
    check("move setup hi", 64'(h0), 64'd11);
    start = 1'b1; op = 2'd1; mthi = 1'b1; operand_a = 32'd3; operand_b = 32'd4;
    @(negedge clock);
    start = 1'b0; mthi = 1'b0;
    check("start wins hi", 64'(hi), 64'd11);
    k = 1;
    while (k <= 100 && !done) begin @(negedge clock); k++; end
    check("start wins result", 64'({hi, lo}), 64'd12);

    // Hazard: hilo_read from cycle 10, mthi while busy
    @(negedge clock);
    h0 = hi; l0 = lo;
    start = 1'b1; op = 2'd0; operand_a = 32'hFFFF_FFFB; operand_b = 32'd9;
    @(negedge clock);
    start = 1'b0;
    k = 1; stall_bad = 0; hold_bad = 0;
    while (k <= 100 && !done) begin
      if (k >= 10) hilo_read = 1'b1;
      if (k == 15) begin mthi = 1'b1; operand_a = 32'hDEAD_BEEF; end
      #1;
      if (busy) begin
        if (stall !== (k >= 10)) stall_bad++;
        if (hi !== h0 || lo !== l0) hold_bad++;
      end
      @(negedge clock);
      k++;
    end
    #1;
    check("hazard stall pattern", 64'(stall_bad), 64'(0));
    check("hazard hilo held", 64'(hold_bad), 64'(0));
    check("hazard latency", 64'(k), 64'd34);
    check("hazard stall after busy", 64'({busy, stall}), 64'(0));
    check("hazard result", 64'({hi, lo}), 64'(model(2'd0, 32'hFFFF_FFFB, 32'd9)));
    hilo_read = 1'b0; mthi = 1'b0;
    @(negedge clock);
    check("mthi while busy ignored", 64'(hi), 64'hFFFF_FFFF);

    // Reset abort mid-operation
    start = 1'b1; op = 2'd1; operand_a = 32'd123; operand_b = 32'd456;
    @(negedge clock);
    start = 1'b0;
    repeat (19) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort hi_lo", 64'({hi, lo}), 64'(0));
    check("abort busy_done", 64'({busy, done}), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("abort no done", 64'(dones), 64'(0));
    check("abort hi_lo stay", 64'({hi, lo, 31'd0, busy}), 64'(0));

    // Random operations vs reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      m = model(ro, ra, rb);
      run_op($sformatf("rand%0d", i), ro, ra, rb, m[63:32], m[31:0], m[64]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
